// File: rtl/pcmux.sv
// Shared redirect-target select encoding used by fetch and execute.
package pcmux;

  typedef enum logic {
    alu_out  = 1'b0,
    alu_mod2 = 1'b1
  } pcmux_sel_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: single outstanding imem request, one-entry output
// register towards decode, branch redirect with stale-response dropping.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                branch_take,
  input  pcmux::pcmux_sel_t   pcmux_sel,
  input  logic [31:0]         alu_out,
  input  logic                stall,
  output logic [31:0]         imem_address,
  output logic                imem_read,
  input  logic                imem_resp,
  input  logic [31:0]         imem_rdata,
  output logic                if_valid,
  output logic [31:0]         if_pc,
  output logic [31:0]         if_instr,
  output logic                flush
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DROP
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] tgt, tgt_n;
  logic [31:0] target;
  logic [31:0] if_pc_n, if_instr_n;
  logic        if_valid_n;

  assign target       = (pcmux_sel == pcmux::alu_mod2) ? {alu_out[31:1], 1'b0} : alu_out;
  assign flush        = branch_take;
  assign imem_address = pc;
  // Gated by rst so no request is visible while reset is held.
  assign imem_read    = rst && (state != HOLD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      tgt      <= '0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      tgt      <= tgt_n;
      if_valid <= if_valid_n;
      if_pc    <= if_pc_n;
      if_instr <= if_instr_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    tgt_n      = tgt;
    if_valid_n = if_valid && stall;
    if_pc_n    = if_pc;
    if_instr_n = if_instr;

    unique case (state)
      FETCH: begin
        if (branch_take) begin
          if_valid_n = 1'b0;
          if (imem_resp) begin
            pc_n = target;
          end else begin
            tgt_n   = target;
            state_n = DROP;
          end
        end else if (imem_resp) begin
          // A freshly filled output register is never consumed in the same
          // cycle, so the next request waits in HOLD until decode takes it.
          if_valid_n = 1'b1;
          if_pc_n    = pc;
          if_instr_n = imem_rdata;
          pc_n       = pc + 32'd4;
          state_n    = HOLD;
        end
      end
      HOLD: begin
        if (branch_take) begin
          if_valid_n = 1'b0;
          pc_n       = target;
          state_n    = FETCH;
        end else if (!stall) begin
          state_n = FETCH;
        end
      end
      DROP: begin
        if (branch_take) begin
          if_valid_n = 1'b0;
          tgt_n      = target;
        end
        if (imem_resp) begin
          pc_n    = branch_take ? target : tgt;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h4000_0000: first fetch address after reset.
REQ-002 SHALL have port clk, input, 1: the single clock.
REQ-003 SHALL have port rst, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port branch_take, input, 1: redirect request from execute.
REQ-005 SHALL have port pcmux_sel, input, pcmux::pcmux_sel_t: redirect target select (alu_out or alu_mod2).
REQ-006 SHALL have port alu_out, input, 32: redirect target from execute.
REQ-007 SHALL have port stall, input, 1: decode cannot accept an instruction this cycle.
REQ-008 SHALL have port imem_address, output, 32: instruction memory word address.
REQ-009 SHALL have port imem_read, output, 1: instruction memory read request.
REQ-010 SHALL have port imem_resp, input, 1: read data valid.
REQ-011 SHALL have port imem_rdata, input, 32: read data.
REQ-012 SHALL have port if_valid, output, 1: if_pc/if_instr hold a valid instruction.
REQ-013 SHALL have port if_pc, output, 32: PC of the presented instruction.
REQ-014 SHALL have port if_instr, output, 32: presented instruction.
REQ-015 SHALL have port flush, output, 1: kill younger IF/ID and ID/EX contents.

Function
REQ-016 SHALL implement states FETCH (request outstanding), HOLD (output full, stalled, no request), and DROP (stale request outstanding, response to be discarded).
REQ-017 SHALL keep imem_read=1 and imem_address stable in FETCH and DROP until imem_resp=1.
REQ-018 SHALL, in FETCH on imem_resp with branch_take=0, register if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, and pc<=pc+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0).
REQ-019 SHALL consume the presented instruction when if_valid=1 and stall=0; if_valid SHALL drop the next cycle unless a new response is registered in that cycle.
REQ-020 SHALL issue the next request only when the output register is empty or consumed in the same cycle; otherwise it SHALL move to HOLD with imem_read=0.
REQ-021 SHALL keep if_pc/if_instr/if_valid unchanged while stall=1 and if_valid=1.
REQ-022 SHALL compute the redirect target as {alu_out[31:1],1'b0} when pcmux_sel==pcmux::alu_mod2, else alu_out.
REQ-023 SHALL drive flush=branch_take combinationally, and SHALL set pc<=target and if_valid<=0 in the cycle after branch_take=1.
REQ-024 SHALL give branch_take priority over stall and over a same-cycle imem_resp; a response arriving with branch_take=1 SHALL be discarded.
REQ-025 SHALL go to DROP on branch_take=1 while a request is outstanding without imem_resp, keep the old address, discard that response, then issue target in FETCH on the following cycle.
REQ-026 SHALL let a later branch_take in DROP overwrite the pending target (last wins).
REQ-027 SHALL go from HOLD to FETCH issuing pc when stall=0 or branch_take=1 (using target).

Reset
REQ-028 SHALL asynchronously set pc=RESET_PC, state=FETCH, if_valid=0, if_pc=0, if_instr=0, imem_read=0 while rst=0.
REQ-029 SHALL assert imem_read with imem_address=RESET_PC in the first cycle after rst deasserts; any request abandoned by reset SHALL be forgotten.

Structure
REQ-030 SHALL take pcmux_sel_t from the shared pcmux package; the state enum SHALL be local; RESET_PC SHALL be a parameter.
REQ-031 SHALL be one flat module without sub-modules.

Verification
REQ-032 Reset release, imem_resp after 2 cycles with 32'h00000013 -> if_valid=1, if_pc=32'h4000_0000, next imem_address=32'h4000_0004.
REQ-033 stall=1 held 3 cycles with if_valid=1 -> if_pc/if_instr constant, imem_read=0, resumes at pc+4 one cycle after stall falls.
REQ-034 branch_take=1, alu_out=32'h4000_0100, request outstanding -> flush=1 same cycle, old response discarded, next request 32'h4000_0100.
REQ-035 branch_take with pcmux_sel=alu_mod2, alu_out=32'h4000_0203, same-cycle imem_resp -> response dropped, next address 32'h4000_0202.
REQ-036 pc=32'hFFFF_FFFC fetched -> next imem_address=32'h0000_0000.
REQ-037 rst pulled low mid-request -> imem_read=0 and if_valid=0 immediately, refetch RESET_PC after release.
